// File: rtl/mpu_mem_ctrl.sv
// mpu_mem_ctrl: sequences one LOAD/STORE/NOP request at a time between the
// MPU request interface and the matrix register file, one element per cycle.
// Optional build macro MPU_MEM_CTRL_PERF_EN adds busy/ops performance counters.
module mpu_mem_ctrl #(
  parameter int FP               = 32,
  parameter int M                = 5,
  parameter int N                = 5,
  parameter int MAX_ELEMENTS     = 9,
  parameter int MATRIX_REGISTERS = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [1:0]                          req_op,
  input  logic [0:MAX_ELEMENTS-1][FP-1:0]     req_matrix_in,
  input  logic [3:0]                          req_m,
  input  logic [3:0]                          req_n,
  input  logic [$clog2(MATRIX_REGISTERS)-1:0] req_addr,
  output logic                                rf_we,
  output logic                                rf_re,
  output logic [$clog2(MATRIX_REGISTERS)-1:0] rf_addr,
  output logic [$clog2(M)-1:0]                rf_row,
  output logic [$clog2(N)-1:0]                rf_col,
  output logic [FP-1:0]                       rf_wdata,
  input  logic [FP-1:0]                       rf_rdata,
  output logic                                rf_dim_we,
  output logic [3:0]                          rf_m,
  output logic [3:0]                          rf_n,
  output logic                                resp_valid,
  input  logic                                resp_ready,
  output logic [1:0]                          resp_op,
  output logic                                resp_error,
  output logic [0:MAX_ELEMENTS-1][FP-1:0]     resp_matrix_out
`ifdef MPU_MEM_CTRL_PERF_EN
  ,
  output logic [15:0]                         perf_busy_cycles,
  output logic [15:0]                         perf_ops_done
`endif
);

  localparam int AW = $clog2(MATRIX_REGISTERS);
  localparam int RW = $clog2(M);
  localparam int CW = $clog2(N);
  localparam logic [3:0] LP_M   = 4'(M);
  localparam logic [3:0] LP_N   = 4'(N);
  localparam logic [7:0] LP_MAX = 8'(MAX_ELEMENTS);

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } mpu_operation_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t                          r_state;
  logic                            r_reqReady;
  logic [3:0]                      r_n;
  logic [3:0]                      r_total;
  logic [3:0]                      r_e;
  logic [0:MAX_ELEMENTS-1][FP-1:0] r_mat;
  logic                            r_rfWe;
  logic                            r_rfRe;
  logic [AW-1:0]                   r_rfAddr;
  logic [RW-1:0]                   r_rfRow;
  logic [CW-1:0]                   r_rfCol;
  logic [FP-1:0]                   r_rfWdata;
  logic                            r_rfDimWe;
  logic [3:0]                      r_rfM;
  logic [3:0]                      r_rfN;
  logic                            r_respValid;
  logic [1:0]                      r_respOp;
  logic                            r_respError;
  logic [0:MAX_ELEMENTS-1][FP-1:0] r_buf;
  logic                            r_pend;
  logic [3:0]                      r_pendIdx;

  logic [7:0]    w_prod;
  logic          w_reqErr;
  logic          w_last;
  logic          w_wrapCol;
  logic [3:0]    w_eNext;
  logic [RW-1:0] w_nextRow;
  logic [CW-1:0] w_nextCol;

  assign w_prod    = {4'd0, req_m} * {4'd0, req_n};
  assign w_reqErr  = (req_m == 4'd0) || (req_n == 4'd0) || (req_m > LP_M) ||
                     (req_n > LP_N) || (w_prod > LP_MAX) || (req_op == 2'd3);
  assign w_last    = (r_e == (r_total - 4'd1));
  assign w_wrapCol = ({{(4-CW){1'b0}}, r_rfCol} == (r_n - 4'd1));
  assign w_eNext   = r_e + 4'd1;
  assign w_nextCol = w_wrapCol ? '0 : r_rfCol + 1'b1;
  assign w_nextRow = w_wrapCol ? r_rfRow + 1'b1 : r_rfRow;

  // Main sequencer: accepts a request, walks the elements row-major, collects
  // read data one cycle behind each read strobe, and holds the response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_reqReady  <= 1'b1;
      r_n         <= '0;
      r_total     <= '0;
      r_e         <= '0;
      r_mat       <= '0;
      r_rfWe      <= 1'b0;
      r_rfRe      <= 1'b0;
      r_rfAddr    <= '0;
      r_rfRow     <= '0;
      r_rfCol     <= '0;
      r_rfWdata   <= '0;
      r_rfDimWe   <= 1'b0;
      r_rfM       <= '0;
      r_rfN       <= '0;
      r_respValid <= 1'b0;
      r_respOp    <= '0;
      r_respError <= 1'b0;
      r_buf       <= '0;
      r_pend      <= 1'b0;
      r_pendIdx   <= '0;
    end else begin
      r_pend    <= 1'b0;
      r_rfDimWe <= 1'b0;
      r_rfM     <= '0;
      r_rfN     <= '0;
      if (r_pend) begin
        r_buf[r_pendIdx] <= rf_rdata;
      end
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_reqReady <= 1'b0;
            r_n        <= req_n;
            r_total    <= w_prod[3:0];
            r_e        <= '0;
            r_mat      <= req_matrix_in;
            r_buf      <= '0;
            if (w_reqErr || (req_op == OP_NOP)) begin
              r_state     <= S_RESP;
              r_respValid <= 1'b1;
              r_respOp    <= req_op;
              r_respError <= w_reqErr;
            end else if (req_op == OP_LOAD) begin
              r_state   <= S_LOAD;
              r_rfWe    <= 1'b1;
              r_rfAddr  <= req_addr;
              r_rfRow   <= '0;
              r_rfCol   <= '0;
              r_rfWdata <= req_matrix_in[0];
              r_rfDimWe <= 1'b1;
              r_rfM     <= req_m;
              r_rfN     <= req_n;
            end else begin
              r_state  <= S_STORE;
              r_rfRe   <= 1'b1;
              r_rfAddr <= req_addr;
              r_rfRow  <= '0;
              r_rfCol  <= '0;
            end
          end
        end
        S_LOAD: begin
          if (w_last) begin
            r_state     <= S_RESP;
            r_rfWe      <= 1'b0;
            r_rfAddr    <= '0;
            r_rfRow     <= '0;
            r_rfCol     <= '0;
            r_rfWdata   <= '0;
            r_respValid <= 1'b1;
            r_respOp    <= OP_LOAD;
            r_respError <= 1'b0;
          end else begin
            r_e       <= w_eNext;
            r_rfRow   <= w_nextRow;
            r_rfCol   <= w_nextCol;
            r_rfWdata <= r_mat[w_eNext];
          end
        end
        S_STORE: begin
          r_pend    <= 1'b1;
          r_pendIdx <= r_e;
          if (w_last) begin
            r_state  <= S_DRAIN;
            r_rfRe   <= 1'b0;
            r_rfAddr <= '0;
            r_rfRow  <= '0;
            r_rfCol  <= '0;
          end else begin
            r_e     <= w_eNext;
            r_rfRow <= w_nextRow;
            r_rfCol <= w_nextCol;
          end
        end
        S_DRAIN: begin
          r_state     <= S_RESP;
          r_respValid <= 1'b1;
          r_respOp    <= OP_STORE;
          r_respError <= 1'b0;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state     <= S_IDLE;
            r_reqReady  <= 1'b1;
            r_respValid <= 1'b0;
            r_respOp    <= '0;
            r_respError <= 1'b0;
            r_buf       <= '0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_reqReady <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready       = r_reqReady;
  assign rf_we           = r_rfWe;
  assign rf_re           = r_rfRe;
  assign rf_addr         = r_rfAddr;
  assign rf_row          = r_rfRow;
  assign rf_col          = r_rfCol;
  assign rf_wdata        = r_rfWdata;
  assign rf_dim_we       = r_rfDimWe;
  assign rf_m            = r_rfM;
  assign rf_n            = r_rfN;
  assign resp_valid      = r_respValid;
  assign resp_op         = r_respOp;
  assign resp_error      = r_respError;
  assign resp_matrix_out = r_buf;

`ifdef MPU_MEM_CTRL_PERF_EN
  logic [15:0] r_perfBusy;
  logic [15:0] r_perfOps;

  // Saturating counters for non-idle cycles and completed response handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perfBusy <= '0;
      r_perfOps  <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_perfBusy != 16'hFFFF)) begin
        r_perfBusy <= r_perfBusy + 16'd1;
      end
      if (r_respValid && resp_ready && (r_perfOps != 16'hFFFF)) begin
        r_perfOps <= r_perfOps + 16'd1;
      end
    end
  end

  assign perf_busy_cycles = r_perfBusy;
  assign perf_ops_done    = r_perfOps;
`endif

endmodule

// File: tb/tb_mpu_mem_ctrl.sv
// tb_mpu_mem_ctrl: directed and randomized checks of mpu_mem_ctrl against a
// behavioural register-file model and an element-level expectation model.
`timescale 1ns/1ps
module tb_mpu_mem_ctrl;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [0:8][31:0]  req_matrix_in;
   logic [3:0]        req_m;
   logic [3:0]        req_n;
   logic [3:0]        req_addr;
   logic              rf_we;
   logic              rf_re;
   logic [3:0]        rf_addr;
   logic [2:0]        rf_row;
   logic [2:0]        rf_col;
   logic [31:0]       rf_wdata;
   logic [31:0]       rf_rdata;
   logic              rf_dim_we;
   logic [3:0]        rf_m;
   logic [3:0]        rf_n;
   logic              resp_valid;
   logic              resp_ready;
   logic [1:0]        resp_op;
   logic              resp_error;
   logic [0:8][31:0]  resp_matrix_out;
`ifdef MPU_MEM_CTRL_PERF_EN
   logic [15:0]       perf_busy_cycles;
   logic [15:0]       perf_ops_done;
`endif

   int checks = 0;
   int failures = 0;
   bit directedMode = 1'b0;

   logic [31:0] refMem [16][8][8];
   logic [31:0] rfMem  [16][8][8];

   mpu_mem_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_op          (req_op),
      .req_matrix_in   (req_matrix_in),
      .req_m           (req_m),
      .req_n           (req_n),
      .req_addr        (req_addr),
      .rf_we           (rf_we),
      .rf_re           (rf_re),
      .rf_addr         (rf_addr),
      .rf_row          (rf_row),
      .rf_col          (rf_col),
      .rf_wdata        (rf_wdata),
      .rf_rdata        (rf_rdata),
      .rf_dim_we       (rf_dim_we),
      .rf_m            (rf_m),
      .rf_n            (rf_n),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_op         (resp_op),
      .resp_error      (resp_error),
      .resp_matrix_out (resp_matrix_out)
`ifdef MPU_MEM_CTRL_PERF_EN
      ,
      .perf_busy_cycles(perf_busy_cycles),
      .perf_ops_done   (perf_ops_done)
`endif
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   // Behavioural register file: writes land on the edge, reads return next cycle.
   always @(posedge clk) begin
      if (rf_we) rfMem[rf_addr][rf_row][rf_col] <= rf_wdata;
      if (rf_re) begin
         if (directedMode)
            rf_rdata <= 32'hA000_0000 + 32'(rf_row) * 32'd3 + 32'(rf_col);
         else
            rf_rdata <= rfMem[rf_addr][rf_row][rf_col];
      end
   end

   // Last-resort guard so the run can never hang.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkResp(input logic [1:0] op, input bit err, input logic [0:8][31:0] expSlot);
      checkOutput("resp_valid_hold", resp_valid, 1);
      checkOutput("resp_op", resp_op, op);
      checkOutput("resp_error", resp_error, err);
      for (int e = 0; e < 9; e++)
         checkOutput($sformatf("slot%0d", e), resp_matrix_out[e], expSlot[e]);
   endtask

   // Waits (bounded) for req_ready at a falling edge, then presents the request.
   task automatic startReq(input logic [1:0] op, input logic [3:0] m, input logic [3:0] n,
                           input logic [3:0] addr, input logic [0:8][31:0] mat,
                           input bit expectReadyNow);
      int guard = 0;
      if (expectReadyNow) checkOutput("req_ready_b2b", req_ready, 1);
      while (req_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) checkOutput("req_ready_timeout", req_ready, 1);
      req_op        = op;
      req_m         = m;
      req_n         = n;
      req_addr      = addr;
      req_matrix_in = mat;
      req_valid     = 1'b1;
   endtask

   // Runs one full transaction and checks every cycle against the rules.
   task automatic applyStimulus(input logic [1:0] op, input logic [3:0] m, input logic [3:0] n,
                                input logic [3:0] addr, input logic [0:8][31:0] mat,
                                input int respDelay, input bit expectReadyNow);
      int total, lat, nn, idx;
      bit err, expWe, expRe;
      logic [0:8][31:0] expSlot;
      nn    = int'(n);
      total = int'(m) * nn;
      err   = (m == 0) || (n == 0) || (m > 5) || (n > 5) || (total > 9) || (op == 2'd3);
      lat   = (err || op == 2'd0) ? 1 : (op == 2'd1) ? total + 1 : total + 2;
      expSlot = '0;
      for (int e = 0; e < 9; e++) begin
         if (!err && op == 2'd2 && e < total)
            expSlot[e] = directedMode ? 32'hA000_0000 + 32'(e) : refMem[addr][e / nn][e % nn];
      end
      if (!err && op == 2'd1)
         for (int e = 0; e < total; e++) refMem[addr][e / nn][e % nn] = mat[e];

      startReq(op, m, n, addr, mat, expectReadyNow);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         expWe = !err && op == 2'd1 && k <= total;
         expRe = !err && op == 2'd2 && k <= total;
         checkOutput("rf_we", rf_we, expWe);
         checkOutput("rf_re", rf_re, expRe);
         checkOutput("rf_dim_we", rf_dim_we, expWe && k == 1);
         checkOutput("resp_valid", resp_valid, k == lat);
         checkOutput("req_ready_busy", req_ready, 0);
         if (expWe || expRe) begin
            idx = k - 1;
            checkOutput("rf_addr", rf_addr, addr);
            checkOutput("rf_row", rf_row, idx / nn);
            checkOutput("rf_col", rf_col, idx % nn);
            if (expWe) checkOutput("rf_wdata", rf_wdata, mat[idx]);
            if (expWe && k == 1) begin
               checkOutput("rf_m", rf_m, m);
               checkOutput("rf_n", rf_n, n);
            end
         end
      end
      checkResp(op, err, expSlot);

      for (int d = 0; d < respDelay; d++) begin
         req_op    = 2'd0;
         req_m     = 4'd1;
         req_n     = 4'd1;
         req_valid = 1'b1;
         @(negedge clk);
         checkResp(op, err, expSlot);
         checkOutput("req_ready_bp", req_ready, 0);
         checkOutput("rf_we_bp", rf_we, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      checkOutput("resp_valid_done", resp_valid, 0);
      checkOutput("req_ready_done", req_ready, 1);
   endtask

   initial begin
      logic [0:8][31:0] mat;
      int a, m, n, rm, rn;

      rst_n = 1'b0;
      req_valid = 1'b0;
      req_op = 2'd0;
      req_m = 4'd0;
      req_n = 4'd0;
      req_addr = 4'd0;
      req_matrix_in = '0;
      resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      $display("[TB] reset state");
      checkOutput("rst_req_ready", req_ready, 1);
      checkOutput("rst_rf_we", rf_we, 0);
      checkOutput("rst_rf_re", rf_re, 0);
      checkOutput("rst_rf_dim_we", rf_dim_we, 0);
      checkOutput("rst_resp_valid", resp_valid, 0);
      checkOutput("rst_resp_error", resp_error, 0);
      checkOutput("rst_rf_wdata", rf_wdata, 0);

      $display("[TB] directed LOAD 3x3");
      for (int e = 0; e < 9; e++) mat[e] = 32'h3F80_0000 + 32'(e);
      applyStimulus(2'd1, 4'd3, 4'd3, 4'd5, mat, 0, 1'b0);

      $display("[TB] directed STORE 2x3 with backpressure");
      directedMode = 1'b1;
      applyStimulus(2'd2, 4'd2, 4'd3, 4'd5, mat, 5, 1'b1);
      directedMode = 1'b0;

      $display("[TB] error requests");
      applyStimulus(2'd1, 4'd0, 4'd3, 4'd1, mat, 0, 1'b1);
      applyStimulus(2'd2, 4'd1, 4'd6, 4'd1, mat, 0, 1'b1);
      applyStimulus(2'd1, 4'd4, 4'd3, 4'd1, mat, 0, 1'b1);
      applyStimulus(2'd3, 4'd2, 4'd2, 4'd1, mat, 0, 1'b1);
      applyStimulus(2'd0, 4'd2, 4'd2, 4'd1, mat, 1, 1'b1);

      $display("[TB] reset during LOAD");
      startReq(2'd1, 4'd3, 4'd3, 4'd7, mat, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         checkOutput("mid_rf_we", rf_we, 1);
      end
      rst_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checkOutput("abort_rf_we", rf_we, 0);
         checkOutput("abort_resp_valid", resp_valid, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rel_req_ready", req_ready, 1);
      checkOutput("rel_rf_we", rf_we, 0);
      checkOutput("rel_rf_re", rf_re, 0);
      checkOutput("rel_rf_addr", rf_addr, 0);
      checkOutput("rel_rf_row", rf_row, 0);
      checkOutput("rel_rf_col", rf_col, 0);
      checkOutput("rel_rf_wdata", rf_wdata, 0);
      checkOutput("rel_rf_dim_we", rf_dim_we, 0);
      checkOutput("rel_rf_m", rf_m, 0);
      checkOutput("rel_rf_n", rf_n, 0);
      checkOutput("rel_resp_valid", resp_valid, 0);
      checkOutput("rel_resp_op", resp_op, 0);
      checkOutput("rel_resp_error", resp_error, 0);
      checkOutput("rel_slot0", resp_matrix_out[0], 0);
      repeat (2) begin
         @(negedge clk);
         checkOutput("idle_rf_we", rf_we, 0);
      end
      mat[0] = 32'hCAFE_0001;
      applyStimulus(2'd1, 4'd1, 4'd1, 4'd7, mat, 0, 1'b1);

      $display("[TB] randomized LOAD/STORE round trips");
      for (int it = 0; it < 8; it++) begin
         a = $urandom_range(0, 15);
         m = $urandom_range(1, 5);
         n = $urandom_range(1, (9 / m > 5) ? 5 : 9 / m);
         for (int e = 0; e < 9; e++) mat[e] = $urandom();
         applyStimulus(2'd1, 4'(m), 4'(n), 4'(a), mat, $urandom_range(0, 2), 1'b1);
         rm = $urandom_range(1, m);
         rn = $urandom_range(1, n);
         applyStimulus(2'd2, 4'(rm), 4'(rn), 4'(a), mat, $urandom_range(0, 3), 1'b1);
         case ($urandom_range(0, 2))
            0: applyStimulus(2'd0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'(a), mat, 0, 1'b1);
            1: applyStimulus(2'd3, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'(a), mat, 0, 1'b1);
            default: applyStimulus(2'd1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                                   4'($urandom_range(0, 15)), mat, 1, 1'b1);
         endcase
      end

`ifdef MPU_MEM_CTRL_PERF_EN
      $display("[TB] performance counters");
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("perf_busy_rst", perf_busy_cycles, 0);
      checkOutput("perf_ops_rst", perf_ops_done, 0);
      applyStimulus(2'd0, 4'd1, 4'd1, 4'd2, mat, 0, 1'b1);
      applyStimulus(2'd1, 4'd1, 4'd1, 4'd2, mat, 0, 1'b1);
      applyStimulus(2'd2, 4'd1, 4'd1, 4'd2, mat, 0, 1'b1);
      checkOutput("perf_ops_done", perf_ops_done, 3);
      checkOutput("perf_busy_cycles", perf_busy_cycles, 6);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mpu_mem_ctrl.md
# mpu_mem_ctrl

Sequencer between the MPU bus-functional request interface and the matrix register file. Accepts one LOAD, STORE or NOP request at a time and serialises a matrix of up to nine 32-bit elements into, or out of, the register file one element per cycle. For STORE it reassembles the elements into a response vector. Sits directly behind the MPU BFM/driver and owns the register file's single write port and single read port.

## Interface
- FP, 32, element width in bits
- M, 5, maximum matrix rows held by the register file
- N, 5, maximum matrix columns held by the register file
- MAX_ELEMENTS, 9, element slots in the request/response vectors
- MATRIX_REGISTERS, 16, number of matrix registers

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  2  mpu_operation_t: NOP=0, LOAD=1, STORE=2; 3 is illegal
- req_matrix_in  in  MAX_ELEMENTS*FP  [0:8][31:0]; element e is row-major, e = r*n + c
- req_m, req_n  in  4 each  matrix rows and columns
- req_addr  in  4  matrix register index
- rf_we  out  1  element write strobe
- rf_re  out  1  element read strobe; rf_rdata is valid on the next cycle
- rf_addr  out  4  matrix register index
- rf_row  out  3  element row
- rf_col  out  3  element column
- rf_wdata  out  FP  element write data
- rf_rdata  in  FP  element read data
- rf_dim_we  out  1  strobe that writes the register's dimension tag
- rf_m, rf_n  out  4 each  dimension tag values
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_op  out  2  echoed operation
- resp_error  out  1  request was rejected
- resp_matrix_out  out  MAX_ELEMENTS*FP  STORE data; unused slots are 0

## Operation
- States: IDLE, LOAD, STORE, DRAIN, RESP.
- req_ready is 1 only in IDLE. A request is accepted on a cycle where req_valid && req_ready.
- On accept, all request fields are captured. Element counter e, row r and column c are reset to 0.
- Error check at accept: resp_error=1 if m==0, n==0, m>M, n>N, m*n>MAX_ELEMENTS, or op==3. An error request goes straight to RESP with no register-file strobes.
- NOP goes straight to RESP with resp_error=0.
- LOAD:
  - Each cycle in LOAD: rf_we=1, rf_wdata=matrix_in[e], rf_row=r, rf_col=c.
  - rf_dim_we=1 with rf_m/rf_n in the first LOAD cycle only.
  - c wraps to 0 at n-1 and r increments at that point.
  - Leave LOAD after element m*n-1 and go to RESP.
- STORE:
  - rf_re=1 per element with the same counting as LOAD.
  - Read data is captured one cycle later into slot e.
  - After the last rf_re, the FSM spends one DRAIN cycle capturing the final element, then goes to RESP.
  - The capture buffer is cleared at accept.
- RESP: resp_valid=1 and all resp_* fields are held stable until resp_ready. On handshake, return to IDLE.
- resp_matrix_out is all-zero for LOAD, NOP and error responses.
- Reset (rst_n=0 at a clock edge), including mid-operation:
  - FSM returns to IDLE and counters clear.
  - req_ready=1 from the first cycle after reset is released.
  - Every other output is 0.
  - No further rf_we or rf_re is issued for the aborted request.

## Timing
- Accept at cycle T.
- LOAD: rf_we is high in cycles T+1 .. T+m*n; resp_valid is high from T+m*n+1.
- STORE: rf_re is high in cycles T+1 .. T+m*n; DRAIN is at T+m*n+1; resp_valid is high from T+m*n+2.
- NOP or error: resp_valid is high from T+1.
- Back-to-back: if resp_ready=1 in the first RESP cycle, req_ready=1 on the next cycle. Minimum request spacing is latency+1.
- rf_we and rf_re are never high in the same cycle.
- resp_valid is never dropped without a handshake.

## Configuration
- MPU_MEM_CTRL_PERF_EN defined:
  - Adds outputs perf_busy_cycles (16 bits) and perf_ops_done (16 bits).
  - perf_busy_cycles counts cycles not in IDLE.
  - perf_ops_done counts completed response handshakes.
  - Both saturate at 16'hFFFF and clear on reset.
- Macro undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- LOAD, m=3, n=3, addr=5, matrix_in[e]=32'h3F80_0000+e:
  - rf_we is high in T+1..T+9 with (row,col) = (0,0),(0,1),(0,2),(1,0)..(2,2) and matching data.
  - rf_dim_we pulses at T+1 with 3/3.
  - resp_valid at T+10 with error=0.
- STORE, m=2, n=3, addr=5, rf_rdata model returns 32'hA000_0000+r*n+c:
  - rf_re is high in T+1..T+6.
  - resp_valid at T+8.
  - Slots 0..5 equal A000_0000..A000_0005; slots 6..8 are 0.
- Errors: m=0; n=6; m=4,n=3 (12 elements); op=3. Each gives resp_valid at T+1, resp_error=1, and zero rf strobes.
- Backpressure: hold resp_ready=0 for 5 cycles during a STORE response.
  - resp fields stay stable and req_ready stays 0.
  - A waiting req_valid is not accepted until the cycle after the handshake.
- Reset mid-operation: drive rst_n=0 at T+4 of a 3x3 LOAD.
  - No rf_we after the reset edge.
  - All outputs are 0 and req_ready=1 after release.
  - A following LOAD, m=1, n=1, completes in 2 cycles.
- With PERF_EN, run NOP, then LOAD 1x1, then STORE 1x1, all with resp_ready=1: perf_ops_done=3 and perf_busy_cycles=1+2+3=6.
